// File: rtl/swap_sequencer.sv
// Generation/frame swap controller: starts a generation, waits for every engine,
// then swaps the double buffer on a qualifying vertical-blank rising edge.
module swap_sequencer #(
    parameter int NUM_ENGINES   = 1,
    parameter int LOG_MAX_SPEED = 3,
    parameter int GEN_WIDTH     = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     vblank_in,
    input  logic [NUM_ENGINES-1:0]   done_in,
    input  logic [1:0]               mode_in,
    input  logic                     step_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    output logic                     start_out,
    output logic                     swap_out,
    output logic                     busy_out,
    output logic [GEN_WIDTH-1:0]     gen_count_out,
    output logic                     overrun_out
);

    localparam int FW = LOG_MAX_SPEED + 1;
    localparam logic [FW-1:0]        FRAME_MAX = FW'(1 << LOG_MAX_SPEED);
    localparam logic [FW-1:0]        FRAME_ONE = FW'(1);
    localparam logic [GEN_WIDTH-1:0] GEN_ONE   = GEN_WIDTH'(1);

    typedef enum logic [1:0] {S_START, S_COMPUTE, S_WAIT, S_SWAP} state_t;

    state_t                   state_q;
    logic                     vblank_q;
    logic                     step_pend_q;
    logic                     start_q;
    logic                     swap_q;
    logic                     busy_q;
    logic                     overrun_q;
    logic [LOG_MAX_SPEED-1:0] speed_lat_q;
    logic [FW-1:0]            frame_cnt_q;
    logic [FW-1:0]            frame_cnt_d;
    logic [GEN_WIDTH-1:0]     gen_q;

    logic          vb_edge;
    logic          all_done;
    logic          run_mode;
    logic          step_mode;
    logic          due;
    logic          swap_cond;
    logic [FW-1:0] need;
    logic [FW:0]   frame_next;

    assign vb_edge    = vblank_in & ~vblank_q;
    assign all_done   = &done_in;
    assign run_mode   = (mode_in == 2'b01);
    assign step_mode  = (mode_in == 2'b10);
    assign need       = FRAME_MAX - {1'b0, speed_lat_q};
    assign frame_next = {1'b0, frame_cnt_q} + {{FW{1'b0}}, 1'b1};
    assign due        = vb_edge & (frame_next >= {1'b0, need});
    assign swap_cond  = run_mode  ? due :
                        step_mode ? (vb_edge & step_pend_q) : 1'b0;
    // Frame counter saturates so a late WAIT entry still qualifies on the next edge.
    assign frame_cnt_d = (vb_edge && (frame_cnt_q != FRAME_MAX)) ? frame_cnt_q + FRAME_ONE
                                                                 : frame_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_START;
            vblank_q    <= 1'b1;
            step_pend_q <= 1'b0;
            start_q     <= 1'b0;
            swap_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            speed_lat_q <= '0;
            frame_cnt_q <= '0;
            gen_q       <= '0;
        end else begin
            vblank_q    <= vblank_in;
            start_q     <= 1'b0;
            swap_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= frame_cnt_d;
            if (step_mode && step_in && (state_q != S_SWAP))
                step_pend_q <= 1'b1;
            case (state_q)
                S_START: begin
                    // Coming out of reset the pulse has not been issued yet.
                    if (!start_q) begin
                        start_q <= 1'b1;
                    end else begin
                        speed_lat_q <= speed_in;
                        frame_cnt_q <= vb_edge ? FRAME_ONE : '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (run_mode && due && !all_done)
                        overrun_q <= 1'b1;
                    if (all_done)
                        state_q <= S_WAIT;
                    else
                        busy_q <= 1'b1;
                end
                S_WAIT: begin
                    if (!all_done) begin
                        busy_q  <= 1'b1;
                        state_q <= S_COMPUTE;
                    end else if (swap_cond) begin
                        swap_q  <= 1'b1;
                        state_q <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    gen_q       <= gen_q + GEN_ONE;
                    step_pend_q <= 1'b0;
                    start_q     <= 1'b1;
                    state_q     <= S_START;
                end
                default: state_q <= S_START;
            endcase
        end
    end

    assign start_out     = start_q;
    assign swap_out      = swap_q;
    assign busy_out      = busy_q;
    assign gen_count_out = gen_q;
    assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_swap_sequencer.sv
// Directed bench for swap_sequencer: table of frame scenarios plus hand-written
// reset-in-WAIT and done-drop sequences, with a two-engine behavioural model.
module tb_swap_sequencer;

    localparam int P = 200;

    logic        clk;
    logic        rst;
    logic        vblank;
    logic [1:0]  done;
    logic [1:0]  mode;
    logic        step;
    logic [2:0]  speed;
    logic        start_o;
    logic        swap_o;
    logic        busy_o;
    logic [15:0] gen_o;
    logic        ovr_o;

    logic [1:0]  eng_done;
    int          eng_cnt [2];
    int          eng_dly [2];
    logic        force_low;

    int compared;
    int mismatched;
    int swap_cnt;
    int follow_err;
    logic prev_swap;

    assign done = eng_done & ~{2{force_low}};

    swap_sequencer #(.NUM_ENGINES(2), .LOG_MAX_SPEED(3), .GEN_WIDTH(16)) dut (
        .clk_in(clk), .rst_in(rst), .vblank_in(vblank), .done_in(done),
        .mode_in(mode), .step_in(step), .speed_in(speed),
        .start_out(start_o), .swap_out(swap_o), .busy_out(busy_o),
        .gen_count_out(gen_o), .overrun_out(ovr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engines drop done on start_out and raise it again after their own delay.
    always @(negedge clk) begin
        for (int e = 0; e < 2; e++) begin
            if (rst) begin
                eng_done[e] = 1'b0;
                eng_cnt[e]  = 0;
            end else if (start_o) begin
                eng_done[e] = 1'b0;
                eng_cnt[e]  = eng_dly[e];
            end else if (eng_cnt[e] > 0) begin
                eng_cnt[e] = eng_cnt[e] - 1;
                if (eng_cnt[e] == 0) eng_done[e] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (swap_o) swap_cnt = swap_cnt + 1;
        if (prev_swap && !start_o) follow_err = follow_err + 1;
        prev_swap = swap_o;
    end

    typedef struct {
        logic [1:0] mode;
        logic [2:0] speed;
        int         dly1;
        int         step_frames;
        int         frames;
        int         exp_swaps;
        int         exp_gen;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        vblank    = 1'b0;
        step      = 1'b0;
        force_low = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_reset_outputs"}, 32'({start_o, swap_o, busy_o, ovr_o, gen_o}), 32'd0);
        rst        = 1'b0;
        swap_cnt   = 0;
        follow_err = 0;
    endtask

    // Each frame is P cycles; the vblank rising edge lands at the frame boundary.
    task automatic run_frames(input int frames, input int step_frames);
        for (int c = 1; c <= frames * P + 5; c++) begin
            vblank = (c >= P) && ((c % P) < 20);
            step   = ((c / P) < step_frames) &&
                     (((c % P) == 100) || ((c % P) == 110) || ((c % P) == 120));
            @(negedge clk);
        end
        vblank = 1'b0;
        step   = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        swap_cnt   = 0;
        follow_err = 0;
        prev_swap  = 1'b0;
        eng_dly[0] = 50;
        eng_dly[1] = 50;
        rst        = 1'b1;
        vblank     = 1'b0;
        step       = 1'b0;
        force_low  = 1'b0;
        mode       = 2'b01;
        speed      = 3'd7;

        //            mode   spd  dly1 stepf frames swaps gen ovr
        vecs[0] = '{2'b01, 3'd7,  50, 0, 3, 3, 3, 1'b0};
        vecs[1] = '{2'b01, 3'd5,  50, 0, 9, 3, 3, 1'b0};
        vecs[2] = '{2'b01, 3'd7, 300, 0, 2, 1, 1, 1'b1};
        vecs[3] = '{2'b10, 3'd7,  50, 1, 3, 1, 1, 1'b0};
        vecs[4] = '{2'b00, 3'd7,  50, 3, 3, 0, 0, 1'b0};
        vecs[5] = '{2'b11, 3'd7,  50, 3, 2, 0, 0, 1'b0};
        vecs[6] = '{2'b10, 3'd7,  50, 3, 3, 3, 3, 1'b0};
        vecs[7] = '{2'b01, 3'd0,  50, 0, 9, 1, 1, 1'b0};
        vecs[8] = '{2'b01, 3'd6,  50, 0, 5, 2, 2, 1'b0};

        for (int i = 0; i < 9; i++) begin
            mode       = vecs[i].mode;
            speed      = vecs[i].speed;
            eng_dly[1] = vecs[i].dly1;
            do_reset($sformatf("v%0d", i));
            run_frames(vecs[i].frames, vecs[i].step_frames);
            check($sformatf("v%0d_swaps", i), swap_cnt, vecs[i].exp_swaps);
            check($sformatf("v%0d_gen", i), 32'(gen_o), vecs[i].exp_gen);
            check($sformatf("v%0d_overrun", i), 32'(ovr_o), 32'(vecs[i].exp_ovr));
            check($sformatf("v%0d_start_follows_swap", i), follow_err, 0);
        end

        // Reset while waiting in WAIT after five generations.
        mode       = 2'b01;
        speed      = 3'd7;
        eng_dly[1] = 50;
        do_reset("rw");
        run_frames(5, 0);
        check("rw_gen_before", 32'(gen_o), 32'd5);
        repeat (60) @(negedge clk);
        check("rw_waiting_not_busy", 32'(busy_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rw_outputs_in_reset", 32'({start_o, swap_o, busy_o, ovr_o, gen_o}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rw_start_after_release", 32'(start_o), 32'd1);
        swap_cnt = 0;
        @(negedge clk);
        check("rw_start_single_cycle", 32'(start_o), 32'd0);
        repeat (100) @(negedge clk);
        check("rw_no_swap_without_edge", swap_cnt, 0);
        run_frames(1, 0);
        check("rw_swap_after_edge", swap_cnt, 1);
        check("rw_gen_after", 32'(gen_o), 32'd1);

        // done_in dropping in WAIT returns to COMPUTE.
        do_reset("dd");
        repeat (60) @(negedge clk);
        check("dd_wait_not_busy", 32'(busy_o), 32'd0);
        force_low = 1'b1;
        repeat (2) @(negedge clk);
        check("dd_busy_again", 32'(busy_o), 32'd1);
        run_frames(1, 0);
        check("dd_no_swap_while_low", swap_cnt, 0);
        check("dd_still_busy", 32'(busy_o), 32'd1);
        force_low = 1'b0;
        repeat (3) @(negedge clk);
        run_frames(1, 0);
        check("dd_swap_after_reassert", swap_cnt, 1);
        check("dd_gen", 32'(gen_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/swap_sequencer.md
Name: swap_sequencer

Overview:
- Generation/frame swap controller between N life-logic engines and the renderer's double buffer.
- Starts a generation, waits for every engine to report done, then pulses buffer swap on a vertical-blank rising edge.
- Swap rate is set by a per-generation speed value and a run/pause/step mode.
- Keeps a generation counter and a sticky overrun flag. Placed at top level between the logic engines, the double buffer and the renderer.

Parameters:
- NUM_ENGINES, 1, number of logic engines whose done flags are ANDed.
- LOG_MAX_SPEED, 3, width of speed_in; one generation per 2^LOG_MAX_SPEED - speed frames.
- GEN_WIDTH, 16, width of generation counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- vblank_in  input  1  high during vertical blanking, from renderer
- done_in  input  NUM_ENGINES  per-engine level done; held high until next start_out
- mode_in  input  2  00 pause, 01 run, 10 step, 11 treated as pause
- step_in  input  1  single-cycle step request, honoured only in step mode
- speed_in  input  LOG_MAX_SPEED  speed; larger value means faster
- start_out  output  1  one-cycle pulse: engines begin the next generation
- swap_out  output  1  one-cycle pulse: double buffer swaps
- busy_out  output  1  high while waiting for engines (COMPUTE)
- gen_count_out  output  GEN_WIDTH  completed generations, wraps
- overrun_out  output  1  sticky: a due frame was missed because engines were not done

Behaviour:
- Reset
  - Clock and reset: all state changes on posedge clk_in; rst_in is synchronous and active-high.
  - While rst_in is high: state=START, all outputs 0, gen_count=0, frame_cnt=0, step_pend=0, speed_lat=0, vblank_q=1.
  - vblank_q=1 means no spurious edge when leaving reset.
  - rst_in mid-operation aborts any state with the same values. start_out is reissued after release.
- Signals
  - edge = vblank_in & ~vblank_q.
  - all_done = &done_in.
  - need = 2^LOG_MAX_SPEED - speed_lat, range 1..2^LOG_MAX_SPEED.
  - frame_cnt is LOG_MAX_SPEED+1 bits. It increments on each edge and saturates at 2^LOG_MAX_SPEED.
  - due = edge & (frame_cnt+1 >= need).
- START
  - start_out=1 for exactly one cycle.
  - speed_lat <= speed_in and frame_cnt <= 0, except an edge in this same cycle counts as 1.
  - Next state: COMPUTE.
- COMPUTE
  - busy_out=1.
  - When all_done, go to WAIT.
  - If mode=run, due occurs and all_done=0 in the same cycle, set overrun_out=1.
- WAIT
  - Swap condition for run: due. For step: edge & step_pend. For pause: never.
  - When the condition holds, go to SWAP. all_done is already known here.
  - done_in dropping in WAIT returns the block to COMPUTE. No swap.
- SWAP
  - swap_out=1 for one cycle.
  - gen_count increments, modulo 2^GEN_WIDTH.
  - step_pend cleared.
  - Next state: START. start_out therefore rises exactly one cycle after swap_out.
- Step handling
  - step_pend is set by step_in when mode=step, in any state except SWAP.
  - Multiple step_in pulses before a swap collapse to one step.
  - step_in in other modes is ignored.
  - Switching mode to step keeps an already-set step_pend.
- Simultaneous events
  - all_done rising in the same cycle as due in COMPUTE: no overrun; the block enters WAIT.
  - The swap then waits for the next qualifying edge. frame_cnt is saturated or already ≥ need, so the next edge in run mode qualifies.
- Latency: edge detected at cycle T, swap_out at T+1, start_out at T+2.
- Timing: outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. LOG_MAX_SPEED=3, speed=7, run, NUM_ENGINES=2, both done 50 cycles after start_out, vblank edge every 1000 cycles. Required: one swap_out per vblank edge, start_out one cycle after each swap_out, gen_count 0→1→2→3 after 3 frames, overrun_out=0.
2. speed=5 (need=3), run. Required: swap_out on every 3rd vblank edge only; 9 frames give gen_count=3.
3. Engine 1 done only 1500 cycles after start, speed=7. Required: overrun_out=1 at first edge; swap on second edge; overrun_out stays 1 until rst_in.
4. Step mode, engines done, three step_in pulses before one edge. Required: exactly one swap_out at that edge, none at the following edges, gen_count +1. Pause mode with step_in pulses: no swaps.
5. rst_in asserted for 1 cycle while in WAIT with gen_count=5. Required: all outputs 0 during reset, gen_count=0, start_out pulse on the first cycle after release, no swap_out until done and an edge occur.
6. done_in deasserted while in WAIT, then reasserted. Required: busy_out returns to 1, no swap_out until reasserted, and swap on the next due edge.
